// File: rtl/bf_sequencer.sv
// bf_sequencer: opcode fetch/decode control and bracket-scan sequencing for the BF machine
module bf_sequencer #(
    parameter int OPW = 4,
    parameter int DW  = 8,
    parameter int AW  = 16,
    parameter int BCW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           PMinputDone,
    input  logic [OPW-1:0] opcode,
    input  logic [AW-1:0]  pc,
    input  logic [DW-1:0]  Dout,
    input  logic [BCW-1:0] BCount,
    input  logic           in_valid,
    input  logic           out_ready,
    output logic           LdPC,
    output logic           PCDecInc,
    output logic           DPEnable,
    output logic           DPDecInc,
    output logic           DEnable,
    output logic           DDecInc,
    output logic           DInChoose,
    output logic           LdOut,
    output logic           BCountEnable,
    output logic           BCountDecInc,
    output logic           ResetBCount,
    output logic           in_ready,
    output logic           out_valid,
    output logic           halted,
    output logic           error
);
    localparam logic [OPW-1:0] opEnd   = OPW'(0);
    localparam logic [OPW-1:0] opRight = OPW'(1);
    localparam logic [OPW-1:0] opLeft  = OPW'(2);
    localparam logic [OPW-1:0] opInc   = OPW'(3);
    localparam logic [OPW-1:0] opDec   = OPW'(4);
    localparam logic [OPW-1:0] opOut   = OPW'(5);
    localparam logic [OPW-1:0] opIn    = OPW'(6);
    localparam logic [OPW-1:0] opOpen  = OPW'(7);
    localparam logic [OPW-1:0] opClose = OPW'(8);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ADVANCE, OUT_WAIT, IN_WAIT,
        SCAN_F_FETCH, SCAN_F_CHECK, SCAN_B_FETCH, SCAN_B_CHECK, HALT
    } stateT;

    stateT state, nextState;
    logic  errFlag, setErr;
    logic  ldPc, pcInc, dpEn, dpInc, dEn, dInc, dIn, ldOut, bcEn, bcInc, bcRst, inRdy, outVld;

    // state register and sticky bracket-fault flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            errFlag <= 1'b0;
        end else begin
            state   <= nextState;
            errFlag <= errFlag | setErr;
        end
    end

    // next-state and strobe decode
    always_comb begin
        nextState = state;
        setErr    = 1'b0;
        ldPc      = 1'b0;
        pcInc     = 1'b0;
        dpEn      = 1'b0;
        dpInc     = 1'b0;
        dEn       = 1'b0;
        dInc      = 1'b0;
        dIn       = 1'b0;
        ldOut     = 1'b0;
        bcEn      = 1'b0;
        bcInc     = 1'b0;
        bcRst     = 1'b0;
        inRdy     = 1'b0;
        outVld    = 1'b0;
        case (state)
            IDLE: begin
                bcRst     = 1'b1;
                nextState = PMinputDone ? FETCH : IDLE;
            end
            FETCH: nextState = DECODE;
            DECODE: begin
                case (opcode)
                    opRight, opLeft: begin
                        dpEn      = 1'b1;
                        dpInc     = opcode == opRight;
                        nextState = ADVANCE;
                    end
                    opInc, opDec: begin
                        dEn       = 1'b1;
                        dInc      = opcode == opInc;
                        nextState = ADVANCE;
                    end
                    opOut: begin
                        ldOut     = 1'b1;
                        nextState = OUT_WAIT;
                    end
                    opIn: nextState = IN_WAIT;
                    opOpen: begin
                        bcRst     = Dout == '0;
                        ldPc      = Dout == '0;
                        pcInc     = Dout == '0;
                        nextState = Dout == '0 ? SCAN_F_FETCH : ADVANCE;
                    end
                    opClose: begin
                        bcRst     = Dout != '0;
                        ldPc      = Dout != '0;
                        nextState = Dout != '0 ? SCAN_B_FETCH : ADVANCE;
                    end
                    opEnd:   nextState = HALT;
                    default: nextState = ADVANCE;
                endcase
            end
            ADVANCE: begin
                ldPc      = 1'b1;
                pcInc     = 1'b1;
                nextState = FETCH;
            end
            OUT_WAIT: begin
                outVld    = 1'b1;
                nextState = out_ready ? ADVANCE : OUT_WAIT;
            end
            IN_WAIT: begin
                inRdy     = 1'b1;
                dEn       = in_valid;
                dIn       = in_valid;
                nextState = in_valid ? ADVANCE : IN_WAIT;
            end
            SCAN_F_FETCH: nextState = SCAN_F_CHECK;
            SCAN_F_CHECK: begin
                if (opcode == opClose && BCount == '0) begin
                    nextState = ADVANCE;
                end else if (opcode == opEnd || pc == '1 || (opcode == opOpen && BCount == '1)) begin
                    setErr    = 1'b1;
                    nextState = HALT;
                end else begin
                    bcEn      = opcode == opOpen || opcode == opClose;
                    bcInc     = opcode == opOpen;
                    ldPc      = 1'b1;
                    pcInc     = 1'b1;
                    nextState = SCAN_F_FETCH;
                end
            end
            SCAN_B_FETCH: nextState = SCAN_B_CHECK;
            SCAN_B_CHECK: begin
                if (opcode == opOpen && BCount == '0) begin
                    nextState = ADVANCE;
                end else if (pc == '0 || (opcode == opClose && BCount == '1)) begin
                    setErr    = 1'b1;
                    nextState = HALT;
                end else begin
                    bcEn      = opcode == opOpen || opcode == opClose;
                    bcInc     = opcode == opClose;
                    ldPc      = 1'b1;
                    nextState = SCAN_B_FETCH;
                end
            end
            HALT:    nextState = HALT;
            default: nextState = IDLE;
        endcase
    end

    // reset forces every output low, including the IDLE bracket-counter clear
    assign {LdPC, PCDecInc, DPEnable, DPDecInc, DEnable, DDecInc, DInChoose, LdOut,
            BCountEnable, BCountDecInc, ResetBCount, in_ready, out_valid, halted, error} =
        reset ? '0 : {ldPc, pcInc, dpEn, dpInc, dEn, dInc, dIn, ldOut,
                      bcEn, bcInc, bcRst, inRdy, outVld, state == HALT, errFlag};
endmodule

// File: tb/tb_bf_sequencer.sv
// tb_bf_sequencer: random and directed BF programs against a high-level interpreter model
module tb_bf_sequencer;
    logic        clock = 1'b0, reset = 1'b1, PMinputDone = 1'b0;
    logic [3:0]  opcode;
    logic [15:0] pc, dp;
    logic [7:0]  Dout, BCount, doutReg;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic LdPC, PCDecInc, DPEnable, DPDecInc, DEnable, DDecInc, DInChoose, LdOut;
    logic BCountEnable, BCountDecInc, ResetBCount, in_ready, out_valid, halted, error;

    bf_sequencer dut (
        .clock(clock), .reset(reset), .PMinputDone(PMinputDone), .opcode(opcode), .pc(pc),
        .Dout(Dout), .BCount(BCount), .in_valid(in_valid), .out_ready(out_ready),
        .LdPC(LdPC), .PCDecInc(PCDecInc), .DPEnable(DPEnable), .DPDecInc(DPDecInc),
        .DEnable(DEnable), .DDecInc(DDecInc), .DInChoose(DInChoose), .LdOut(LdOut),
        .BCountEnable(BCountEnable), .BCountDecInc(BCountDecInc), .ResetBCount(ResetBCount),
        .in_ready(in_ready), .out_valid(out_valid), .halted(halted), .error(error)
    );

    always #5 clock = ~clock;

    wire [14:0] outs = {LdPC, PCDecInc, DPEnable, DPDecInc, DEnable, DDecInc, DInChoose, LdOut,
                        BCountEnable, BCountDecInc, ResetBCount, in_ready, out_valid, halted, error};

    logic [3:0] prog [1024];
    logic [7:0] ram [256];
    logic [7:0] ramInit [256];
    logic [7:0] inData [64];
    logic       envLoad = 1'b0;
    logic       ioMode = 1'b0;
    int         inIdx;
    int checks = 0, failures = 0, writes = 0, inReadyCycles = 0, cyc = 0;
    int deCycles [$];
    logic [7:0] expQ [$];
    logic       mErr, mOk;
    int         mPc, mWrites;
    logic [7:0] mCells [8];

    // external datapath: PC, DP, bracket counter, DOut register, program/data memories
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0; dp <= '0; BCount <= '0; opcode <= '0; Dout <= '0; doutReg <= '0; inIdx <= 0;
        end else begin
            opcode <= pc < 16'd1024 ? prog[pc[9:0]] : 4'd0;
            Dout   <= ram[dp[7:0]];
            if (LdPC) pc <= PCDecInc ? pc + 16'd1 : pc - 16'd1;
            if (DPEnable) dp <= DPDecInc ? dp + 16'd1 : dp - 16'd1;
            if (ResetBCount) BCount <= '0;
            else if (BCountEnable) BCount <= BCountDecInc ? BCount + 8'd1 : BCount - 8'd1;
            if (LdOut) doutReg <= Dout;
            if (DEnable && DInChoose) inIdx <= inIdx + 1;
        end
    end

    always @(posedge clock) begin
        if (envLoad) ram <= ramInit;
        else if (DEnable)
            ram[dp[7:0]] <= DInChoose ? inData[inIdx[5:0]] : (DDecInc ? Dout + 8'd1 : Dout - 8'd1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // handshake driver: random in_valid/out_ready, or a fixed 5-cycle input delay
    initial forever begin
        @(posedge clock);
        #1;
        if (ioMode) begin
            in_valid  = inReadyCycles >= 4;
            out_ready = 1'b1;
        end else begin
            in_valid  = ($urandom % 3) == 0;
            out_ready = ($urandom % 2) == 0;
        end
    end

    // monitor: scoreboard for emitted bytes plus write/handshake bookkeeping
    always @(negedge clock) begin
        if (!reset) begin
            cyc++;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra actual=%0h required=none", doutReg);
                end else check("out_byte", {24'b0, doutReg}, {24'b0, expQ.pop_front()});
            end
            if (DEnable) begin
                writes++;
                deCycles.push_back(cyc);
            end
            if (DEnable && DInChoose) check("in_handshake", {30'b0, in_valid, in_ready}, 32'd3);
            if (in_ready) inReadyCycles++;
        end
    end

    function automatic logic [3:0] opAt(input int a);
        return (a >= 0 && a < 1024) ? prog[a] : 4'd0;
    endfunction

    // reference interpreter: runs the program directly on a cell array
    task automatic runModel();
        logic [7:0] c [256];
        int p = 0, d = 0, ii = 0, steps = 0, dep, q;
        logic done = 1'b0;
        c = ramInit;
        mErr = 1'b0; mOk = 1'b1; mWrites = 0;
        expQ.delete();
        while (!done) begin
            steps++;
            if (steps > 300) begin
                mOk = 1'b0;
                done = 1'b1;
            end else case (opAt(p))
                0: done = 1'b1;
                1: begin d = (d + 1) & 255; p++; end
                2: begin d = (d + 255) & 255; p++; end
                3: begin c[d] = c[d] + 8'd1; mWrites++; p++; end
                4: begin c[d] = c[d] - 8'd1; mWrites++; p++; end
                5: begin expQ.push_back(c[d]); p++; end
                6: begin c[d] = inData[ii & 63]; ii++; mWrites++; p++; end
                7: begin
                    if (c[d] == 0) begin
                        q = p + 1; dep = 0;
                        while (1) begin
                            if (opAt(q) == 8 && dep == 0) break;
                            if (opAt(q) == 0 || (opAt(q) == 7 && dep == 255)) begin mErr = 1'b1; break; end
                            if (opAt(q) == 7) dep++;
                            if (opAt(q) == 8) dep--;
                            q++;
                        end
                        p = q;
                    end
                    if (mErr) done = 1'b1; else p++;
                end
                8: begin
                    if (c[d] != 0) begin
                        q = p - 1; dep = 0;
                        while (1) begin
                            if (opAt(q) == 7 && dep == 0) break;
                            if (q <= 0 || (opAt(q) == 8 && dep == 255)) begin mErr = 1'b1; break; end
                            if (opAt(q) == 8) dep++;
                            if (opAt(q) == 7) dep--;
                            q--;
                        end
                        p = q;
                    end
                    if (mErr) done = 1'b1; else p++;
                end
                default: p++;
            endcase
        end
        mPc = p;
        for (int i = 0; i < 8; i++) mCells[i] = c[i];
    endtask

    task automatic loadProg(input string s);
        for (int i = 0; i < 1024; i++) prog[i] = 4'd0;
        for (int i = 0; i < s.len(); i++)
            case (s[i])
                ">": prog[i] = 4'd1;
                "<": prog[i] = 4'd2;
                "+": prog[i] = 4'd3;
                "-": prog[i] = 4'd4;
                ".": prog[i] = 4'd5;
                ",": prog[i] = 4'd6;
                "[": prog[i] = 4'd7;
                "]": prog[i] = 4'd8;
                default: prog[i] = 4'd9;
            endcase
    endtask

    task automatic clearCounters();
        writes = 0; inReadyCycles = 0;
        deCycles.delete();
    endtask

    task automatic startRun();
        reset = 1'b1; PMinputDone = 1'b0; envLoad = 1'b1;
        repeat (2) @(posedge clock);
        envLoad = 1'b0;
        runModel();
        clearCounters();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outs", {17'b0, outs}, 32'h10);
        PMinputDone = 1'b1;
    endtask

    task automatic finishRun(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clock);
            n++;
        end
        #1;
        PMinputDone = 1'b0;
        check("halt_reached", {31'b0, halted}, 32'd1);
        check("halt_outs", {17'b0, outs}, {30'b0, 1'b1, mErr});
        check("halt_pc", {16'b0, pc}, mPc);
        check("out_drained", expQ.size(), 0);
        check("write_count", writes, mWrites);
        for (int i = 0; i < 8; i++) check("cell", {24'b0, ram[i]}, {24'b0, mCells[i]});
    endtask

    initial begin
        int n, dep, len, r;
        for (int i = 0; i < 256; i++) ramInit[i] = 8'd0;
        for (int i = 0; i < 64; i++) inData[i] = 8'($urandom);

        loadProg("+++.");
        startRun();
        finishRun(2000);
        check("de_spacing0", deCycles.size() >= 3 ? deCycles[1] - deCycles[0] : -1, 3);
        check("de_spacing1", deCycles.size() >= 3 ? deCycles[2] - deCycles[1] : -1, 3);

        loadProg("[+]");
        startRun();
        finishRun(2000);

        loadProg("+[-]");
        startRun();
        finishRun(2000);

        ioMode = 1'b1;
        inData[0] = 8'h41;
        loadProg(",");
        startRun();
        finishRun(2000);
        check("in_ready_cycles", inReadyCycles, 5);
        ioMode = 1'b0;

        loadProg("[[]");
        startRun();
        finishRun(2000);

        loadProg("+]");
        startRun();
        finishRun(2000);

        for (int i = 0; i < 1024; i++) prog[i] = 4'd0;
        for (int i = 0; i <= 256; i++) prog[i] = 4'd7;
        startRun();
        finishRun(5000);

        loadProg("[++++++++++++++++++++]");
        startRun();
        n = 0;
        while (!(LdPC && ResetBCount) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("scan_started", {31'b0, LdPC && ResetBCount}, 32'd1);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("reset_outs", {17'b0, outs}, 32'd0);
        PMinputDone = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clearCounters();
        @(negedge clock);
        check("reidle_outs", {17'b0, outs}, 32'h10);
        PMinputDone = 1'b1;
        finishRun(2000);

        for (int t = 0; t < 20; t++) begin
            mOk = 1'b0;
            for (int tries = 0; tries < 50 && !mOk; tries++) begin
                for (int i = 0; i < 1024; i++) prog[i] = 4'd0;
                for (int i = 0; i < 8; i++) ramInit[i] = 8'($urandom_range(0, 3));
                len = $urandom_range(4, 16);
                dep = 0;
                n = 0;
                for (int i = 0; i < len; i++) begin
                    r = $urandom % 10;
                    case (r)
                        0: prog[n] = 4'd1;
                        1: prog[n] = 4'd2;
                        2, 3: prog[n] = 4'd3;
                        4: prog[n] = 4'd4;
                        5: prog[n] = 4'd5;
                        6: prog[n] = 4'd6;
                        7: begin prog[n] = dep < 3 ? 4'd7 : 4'd3; if (dep < 3) dep++; end
                        8: begin prog[n] = dep > 0 ? 4'd8 : 4'd4; if (dep > 0) dep--; end
                        default: prog[n] = 4'(9 + $urandom % 7);
                    endcase
                    n++;
                end
                while (dep > 0) begin prog[n] = 4'd8; n++; dep--; end
                runModel();
            end
            startRun();
            finishRun(20000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
